// File: rtl/cmp_sort_ctrl_pkg.sv
// Shared definitions for the 4-element compare/swap sorter: FSM encoding and
// the fixed compare-pair schedule.
package cmp_sort_ctrl_pkg;

    typedef enum logic [1:0] {
        StLoad = 2'd0,
        StSort = 2'd1,
        StOut  = 2'd2
    } state_e;

    localparam int unsigned NumElems = 4;
    localparam int unsigned NumSteps = 6;

    // Left index of the compared pair per sort step; right index is always left + 1.
    // Step order 0..5 compares (0,1),(1,2),(2,3),(0,1),(1,2),(0,1).
    localparam logic [NumSteps-1:0][1:0] SortSched = {2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};

endpackage

// File: rtl/mag_cmp4.sv
// Unsigned W-bit magnitude comparator; the sorter's single shared compare unit.
module mag_cmp4 #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         agreat,
    output logic         aless,
    output logic         equal
);

    always_comb begin
        agreat = (a > b);
        aless  = (a < b);
        equal  = (a == b);
    end

endmodule

// File: rtl/cmp_sort_ctrl.sv
// Load four elements, bubble-sort them in six compare cycles through one
// shared comparator, then stream them out with a valid/ready handshake.
module cmp_sort_ctrl
    import cmp_sort_ctrl_pkg::*;
#(
    parameter int unsigned W    = 4,
    parameter bit          DESC = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last,
    input  logic         out_ready,
    output logic         busy,
    output logic [2:0]   swap_cnt
);

    state_e         state_q, state_d;
    logic [W-1:0]   e_q [NumElems];
    logic [W-1:0]   e_d [NumElems];
    logic [1:0]     ld_idx_q, ld_idx_d;
    logic [1:0]     out_idx_q, out_idx_d;
    logic [2:0]     step_q, step_d;
    logic [2:0]     swap_cnt_q, swap_cnt_d;

    logic [1:0]     cmp_left, cmp_right;
    logic           cmp_gt, cmp_lt, cmp_eq;
    logic           do_swap;

    always_comb begin
        cmp_left  = SortSched[step_q];
        cmp_right = cmp_left + 2'd1;
    end

    mag_cmp4 #(
        .W(W)
    ) u_cmp (
        .a      (e_q[cmp_left]),
        .b      (e_q[cmp_right]),
        .agreat (cmp_gt),
        .aless  (cmp_lt),
        .equal  (cmp_eq)
    );

    // Equal pairs never swap, keeping the sort stable.
    always_comb do_swap = !cmp_eq && (DESC ? cmp_lt : cmp_gt);

    always_comb begin
        state_d    = state_q;
        e_d        = e_q;
        ld_idx_d   = ld_idx_q;
        out_idx_d  = out_idx_q;
        step_d     = step_q;
        swap_cnt_d = swap_cnt_q;

        unique case (state_q)
            StLoad: begin
                if (in_valid) begin
                    e_d[ld_idx_q] = in_data;
                    ld_idx_d      = ld_idx_q + 2'd1;
                    if (ld_idx_q == 2'd3) begin
                        state_d    = StSort;
                        step_d     = 3'd0;
                        swap_cnt_d = 3'd0;
                    end
                end
            end
            StSort: begin
                if (do_swap) begin
                    e_d[cmp_left]  = e_q[cmp_right];
                    e_d[cmp_right] = e_q[cmp_left];
                    swap_cnt_d     = swap_cnt_q + 3'd1;
                end
                if (step_q == 3'(NumSteps - 1)) begin
                    state_d = StOut;
                    step_d  = 3'd0;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            StOut: begin
                if (out_ready) begin
                    out_idx_d = out_idx_q + 2'd1;
                    if (out_idx_q == 2'd3) begin
                        state_d = StLoad;
                    end
                end
            end
            default: state_d = StLoad;
        endcase

        // Flush wins over everything; element contents are deliberately kept.
        if (flush) begin
            state_d    = StLoad;
            e_d        = e_q;
            ld_idx_d   = 2'd0;
            out_idx_d  = 2'd0;
            step_d     = 3'd0;
            swap_cnt_d = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StLoad;
            ld_idx_q   <= 2'd0;
            out_idx_q  <= 2'd0;
            step_q     <= 3'd0;
            swap_cnt_q <= 3'd0;
            for (int i = 0; i < NumElems; i++) begin
                e_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ld_idx_q   <= ld_idx_d;
            out_idx_q  <= out_idx_d;
            step_q     <= step_d;
            swap_cnt_q <= swap_cnt_d;
            for (int i = 0; i < NumElems; i++) begin
                e_q[i] <= e_d[i];
            end
        end
    end

    always_comb begin
        in_ready  = (state_q == StLoad);
        out_valid = (state_q == StOut);
        busy      = (state_q == StSort);
        out_data  = out_valid ? e_q[out_idx_q] : '0;
        out_last  = out_valid && (out_idx_q == 2'd3);
        swap_cnt  = swap_cnt_q;
    end

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Scoreboard bench: an ascending and a descending sorter share one stimulus stream.
module tb_cmp_sort_ctrl;

    typedef logic [3:0] vec4_t [4];
    typedef struct packed {
        logic [3:0] data;
        logic       last;
    } exp_t;

    logic       clk, rst_n, flush, in_valid, out_ready;
    logic [3:0] in_data;
    logic       in_ready_a, out_valid_a, out_last_a, busy_a;
    logic       in_ready_d, out_valid_d, out_last_d, busy_d;
    logic [3:0] out_data_a, out_data_d;
    logic [2:0] swap_cnt_a, swap_cnt_d;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q_asc[$];
    exp_t q_desc[$];
    int   exp_sw_a, exp_sw_d;

    cmp_sort_ctrl #(.W(4), .DESC(1'b0)) dut_asc (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_a), .out_valid(out_valid_a), .out_data(out_data_a),
        .out_last(out_last_a), .out_ready(out_ready), .busy(busy_a), .swap_cnt(swap_cnt_a)
    );

    cmp_sort_ctrl #(.W(4), .DESC(1'b1)) dut_desc (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_d), .out_valid(out_valid_d), .out_data(out_data_d),
        .out_last(out_last_d), .out_ready(out_ready), .busy(busy_d), .swap_cnt(swap_cnt_d)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference: the fixed six-step compare schedule applied to a copy of the data.
    function automatic void model(input vec4_t v, input bit desc, output vec4_t s, output int sw);
        int l;
        logic [3:0] t;
        s  = v;
        sw = 0;
        for (int k = 0; k < 6; k++) begin
            l = (k == 0 || k == 3 || k == 5) ? 0 : ((k == 1 || k == 4) ? 1 : 2);
            if (desc ? (s[l] < s[l+1]) : (s[l] > s[l+1])) begin
                t = s[l]; s[l] = s[l+1]; s[l+1] = t;
                sw++;
            end
        end
    endfunction

    task automatic push_expected(input vec4_t v);
        vec4_t sa, sd;
        model(v, 1'b0, sa, exp_sw_a);
        model(v, 1'b1, sd, exp_sw_d);
        for (int i = 0; i < 4; i++) begin
            q_asc.push_back('{data: sa[i], last: (i == 3)});
            q_desc.push_back('{data: sd[i], last: (i == 3)});
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && !flush && out_ready) begin
            if (out_valid_a) begin
                if (q_asc.size() == 0) check_eq("asc_spurious_out", 1, 0);
                else begin
                    e = q_asc.pop_front();
                    check_eq("asc_data", out_data_a, e.data);
                    check_eq("asc_last", out_last_a, e.last);
                end
            end
            if (out_valid_d) begin
                if (q_desc.size() == 0) check_eq("desc_spurious_out", 1, 0);
                else begin
                    e = q_desc.pop_front();
                    check_eq("desc_data", out_data_d, e.data);
                    check_eq("desc_last", out_last_d, e.last);
                end
            end
        end
    end

    task automatic check_idle(input string tag, input bit with_data);
        check_eq({tag, "_in_ready_a"}, in_ready_a, 1);
        check_eq({tag, "_in_ready_d"}, in_ready_d, 1);
        check_eq({tag, "_out_valid_a"}, out_valid_a, 0);
        check_eq({tag, "_out_valid_d"}, out_valid_d, 0);
        check_eq({tag, "_busy_a"}, busy_a, 0);
        check_eq({tag, "_swap_a"}, swap_cnt_a, 0);
        check_eq({tag, "_swap_d"}, swap_cnt_d, 0);
        if (with_data) begin
            check_eq({tag, "_out_last_a"}, out_last_a, 0);
            check_eq({tag, "_out_data_a"}, out_data_a, 0);
            check_eq({tag, "_out_data_d"}, out_data_d, 0);
        end
    endtask

    task automatic load4(input vec4_t v);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = v[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        push_expected(v);
        check_eq("busy_after_load", busy_a, 1);
        check_eq("in_ready_in_sort", in_ready_a, 0);
    endtask

    task automatic wait_first_out();
        int n = 0;
        while (!out_valid_a && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("first_out_latency", n, 6);
    endtask

    task automatic drain();
        int k = 0;
        while ((q_asc.size() != 0 || q_desc.size() != 0) && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq("drained", q_asc.size() + q_desc.size(), 0);
        check_eq("back_to_load", in_ready_a, 1);
        check_eq("swap_cnt_asc", swap_cnt_a, exp_sw_a);
        check_eq("swap_cnt_desc", swap_cnt_d, exp_sw_d);
    endtask

    task automatic run_case(input vec4_t v);
        load4(v);
        wait_first_out();
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        clk = 0; rst_n = 0; flush = 0; in_valid = 0; in_data = 0; out_ready = 1;
        #12;
        check_idle("reset", 1'b1);
        rst_n = 1;

        run_case('{4'd5, 4'd7, 4'd1, 4'd2});
        check_eq("swap_5712", swap_cnt_a, 4);
        run_case('{4'd10, 4'd8, 4'd3, 4'd1});
        check_eq("swap_10831", swap_cnt_a, 6);
        run_case('{4'd1, 4'd3, 4'd8, 4'd10});
        check_eq("swap_desc_13810", swap_cnt_d, 6);
        run_case('{4'd12, 4'd12, 4'd12, 4'd12});

        // Backpressure: hold the first output for five cycles.
        out_ready = 1'b0;
        load4('{4'd5, 4'd7, 4'd1, 4'd2});
        wait_first_out();
        for (int i = 0; i < 5; i++) begin
            check_eq("hold_valid", out_valid_a, 1);
            check_eq("hold_data_a", out_data_a, q_asc[0].data);
            check_eq("hold_data_d", out_data_d, q_desc[0].data);
            check_eq("hold_last", out_last_a, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        drain();

        // Asynchronous reset in the third sort cycle.
        load4('{4'd9, 4'd2, 4'd6, 4'd4});
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("busy_before_rst", busy_a, 1);
        #2 rst_n = 1'b0;
        #1;
        check_idle("mid_sort_reset", 1'b1);
        q_asc.delete();
        q_desc.delete();
        #2 rst_n = 1'b1;
        run_case('{4'd4, 4'd3, 4'd2, 4'd1});

        // Flush after two elements have drained.
        load4('{4'd8, 4'd2, 4'd9, 4'd4});
        wait_first_out();
        k = 0;
        while (q_asc.size() > 2 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq("two_drained", q_asc.size(), 2);
        out_ready = 1'b0;
        flush     = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_idle("flush", 1'b0);
        q_asc.delete();
        q_desc.delete();
        out_ready = 1'b1;
        run_case('{4'd6, 4'd1, 4'd5, 4'd3});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
